// File: rtl/multicycle_control_pkg.sv
// Shared types for the multicycle MIPS control FSM and the datapath muxes it drives.
package multicycle_control_pkg;

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      FETCH     = 4'd1,
      DECODE    = 4'd2,
      MEM_ADDR  = 4'd3,
      MEM_READ  = 4'd4,
      MEM_WB    = 4'd5,
      MEM_WRITE = 4'd6,
      R_EXEC    = 4'd7,
      R_WB      = 4'd8,
      BRANCH    = 4'd9,
      ADDI_EXEC = 4'd10,
      JUMP      = 4'd11,
      ADDI_WB   = 4'd12
   } mc_state_type;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [1:0] ALUB_RT      = 2'b00;
   localparam logic [1:0] ALUB_FOUR    = 2'b01;
   localparam logic [1:0] ALUB_IMM     = 2'b10;
   localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // States that hold on a memory handshake and are subject to the timeout.
   function automatic logic is_wait_state(mc_state_type s);
      return (s == FETCH) || (s == MEM_READ) || (s == MEM_WRITE);
   endfunction

endpackage

// File: rtl/multicycle_control_wait_timer.sv
// Memory-wait cycle counter with timeout compare; MEM_TIMEOUT = 0 disables expiry.
module mc_wait_timer #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   generate
      if (MEM_TIMEOUT > 0) begin : g_timeout
         assign expired = (cnt_q == CNT_W'(MEM_TIMEOUT));
      end else begin : g_no_timeout
         assign expired = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: sequences IF/ID/EX/MEM/WB and drives all datapath selects.
// Define MULTICYCLE_JUMP_EN to decode opcode 0x02 (j); otherwise it is treated as illegal.
module multicycle_control
   import multicycle_control_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       pcWrite,
   output logic       pcWriteCond,
   output logic       iorD,
   output logic       memRead,
   output logic       memWrite,
   output logic       irWrite,
   output logic       memToReg,
   output logic       regDst,
   output logic       regWrite,
   output logic       aluSrcA,
   output logic [1:0] aluSrcB,
   output logic [1:0] aluOp,
   output logic [1:0] pcSource,
   output logic [3:0] state,
   output logic       retire,
   output logic       illegal_op,
   output logic       mem_fault
);

   mc_state_type state_q, state_d;
   logic         expired;
   logic         timeout;
   logic         tmr_inc;
   logic         tmr_clr;

   assign tmr_inc = is_wait_state(state_q) && !mem_ready;
   assign timeout = tmr_inc && expired;
   // Any state change (including the timeout re-entry) starts a fresh wait count.
   assign tmr_clr = timeout || (state_d != state_q);
   assign state   = state_q;

   mc_wait_timer #(
      .MEM_TIMEOUT(MEM_TIMEOUT)
   ) u_wait_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (tmr_clr),
      .inc    (tmr_inc),
      .expired(expired)
   );

   always_ff @(posedge clk) begin
      // NOTE: reset is sampled on the edge, and <= keeps every flop reading pre-edge values.
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      state_d     = state_q;
      pcWrite     = 1'b0;
      pcWriteCond = 1'b0;
      iorD        = 1'b0;
      memRead     = 1'b0;
      memWrite    = 1'b0;
      irWrite     = 1'b0;
      memToReg    = 1'b0;
      regDst      = 1'b0;
      regWrite    = 1'b0;
      aluSrcA     = 1'b0;
      aluSrcB     = ALUB_RT;
      aluOp       = ALUOP_ADD;
      pcSource    = PCSRC_ALU;
      retire      = 1'b0;
      illegal_op  = 1'b0;
      mem_fault   = 1'b0;

      case (state_q)
         IDLE: state_d = FETCH;
         FETCH: begin
            memRead = 1'b1;
            aluSrcB = ALUB_FOUR;
            irWrite = mem_ready;
            pcWrite = mem_ready;
            if (mem_ready) state_d = DECODE;
         end
         DECODE: begin
            aluSrcB = ALUB_IMM_SH2;
            case (opcode)
               OP_RTYPE:     state_d = R_EXEC;
               OP_LW, OP_SW: state_d = MEM_ADDR;
               OP_BEQ:       state_d = BRANCH;
               OP_ADDI:      state_d = ADDI_EXEC;
`ifdef MULTICYCLE_JUMP_EN
               OP_J:         state_d = JUMP;
`endif
               default: begin
                  illegal_op = 1'b1;
                  state_d    = FETCH;
               end
            endcase
         end
         MEM_ADDR: begin
            aluSrcA = 1'b1;
            aluSrcB = ALUB_IMM;
            state_d = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
         end
         MEM_READ: begin
            memRead = 1'b1;
            iorD    = 1'b1;
            if (mem_ready) state_d = MEM_WB;
         end
         MEM_WB: begin
            regWrite = 1'b1;
            memToReg = 1'b1;
            retire   = 1'b1;
            state_d  = FETCH;
         end
         MEM_WRITE: begin
            memWrite = 1'b1;
            iorD     = 1'b1;
            retire   = mem_ready;
            if (mem_ready) state_d = FETCH;
         end
         R_EXEC: begin
            aluSrcA = 1'b1;
            aluOp   = ALUOP_FUNCT;
            state_d = R_WB;
         end
         R_WB: begin
            regWrite = 1'b1;
            regDst   = 1'b1;
            retire   = 1'b1;
            state_d  = FETCH;
         end
         BRANCH: begin
            aluSrcA     = 1'b1;
            aluOp       = ALUOP_SUB;
            pcWriteCond = 1'b1;
            pcSource    = PCSRC_ALUOUT;
            retire      = 1'b1;
            state_d     = FETCH;
         end
         ADDI_EXEC: begin
            aluSrcA = 1'b1;
            aluSrcB = ALUB_IMM;
            state_d = ADDI_WB;
         end
         ADDI_WB: begin
            regWrite = 1'b1;
            retire   = 1'b1;
            state_d  = FETCH;
         end
`ifdef MULTICYCLE_JUMP_EN
         JUMP: begin
            pcWrite  = 1'b1;
            pcSource = PCSRC_JUMP;
            retire   = 1'b1;
            state_d  = FETCH;
         end
`endif
         default: state_d = IDLE;
      endcase

      // A stalled access that hits the limit is abandoned and the fetch restarts.
      if (timeout) begin
         mem_fault = 1'b1;
         irWrite   = 1'b0;
         pcWrite   = 1'b0;
         retire    = 1'b0;
         state_d   = FETCH;
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected state/controls queued and checked.
module tb_multicycle_control;
   import multicycle_control_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
   logic       memToReg, regDst, regWrite, aluSrcA;
   logic [1:0] aluSrcB, aluOp, pcSource;
   logic [3:0] state;
   logic       retire, illegal_op, mem_fault;

   typedef struct packed {
      logic       pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write;
      logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
      logic [1:0] alu_src_b, alu_op, pc_source;
      logic       retire, illegal_op, mem_fault;
   } ctrl_t;

   typedef struct {
      string      tag;
      logic [3:0] st;
      ctrl_t      ctl;
   } exp_t;

   exp_t  sb_q[$];
   int    n_cmp  = 0;
   int    n_fail = 0;
   ctrl_t obs;

   assign obs = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg, regDst,
                 regWrite, aluSrcA, aluSrcB, aluOp, pcSource, retire, illegal_op, mem_fault};

   always #5 clk = ~clk;

   multicycle_control #(.MEM_TIMEOUT(15)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD), .memRead(memRead),
      .memWrite(memWrite), .irWrite(irWrite), .memToReg(memToReg), .regDst(regDst),
      .regWrite(regWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
      .pcSource(pcSource), .state(state), .retire(retire), .illegal_op(illegal_op),
      .mem_fault(mem_fault)
   );

   function automatic logic op_legal(logic [5:0] op);
      logic ok;
      ok = (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h08);
`ifdef MULTICYCLE_JUMP_EN
      ok = ok || (op == 6'h02);
`endif
      return ok;
   endfunction

   // Reference control word for a state, straight from the state table.
   function automatic ctrl_t model(mc_state_type st, logic [5:0] op, logic mr, logic fault);
      ctrl_t c;
      c = '0;
      case (st)
         FETCH: begin
            c.mem_read = 1'b1; c.alu_src_b = 2'b01;
            c.ir_write = mr & ~fault; c.pc_write = mr & ~fault; c.mem_fault = fault;
         end
         DECODE:    begin c.alu_src_b = 2'b11; c.illegal_op = ~op_legal(op); end
         MEM_ADDR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
         MEM_READ:  begin c.mem_read = 1'b1; c.ior_d = 1'b1; c.mem_fault = fault; end
         MEM_WB:    begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.retire = 1'b1; end
         MEM_WRITE: begin
            c.mem_write = 1'b1; c.ior_d = 1'b1; c.retire = mr & ~fault; c.mem_fault = fault;
         end
         R_EXEC:    begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
         R_WB:      begin c.reg_write = 1'b1; c.reg_dst = 1'b1; c.retire = 1'b1; end
         BRANCH: begin
            c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_write_cond = 1'b1;
            c.pc_source = 2'b01; c.retire = 1'b1;
         end
         ADDI_EXEC: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
         ADDI_WB:   begin c.reg_write = 1'b1; c.retire = 1'b1; end
         JUMP:      begin c.pc_write = 1'b1; c.pc_source = 2'b10; c.retire = 1'b1; end
         default:   c = '0;
      endcase
      return c;
   endfunction

   task automatic check_out();
      exp_t e;
      n_cmp++;
      assert (sb_q.size() > 0) else begin
         n_fail++;
         $error("FAIL scoreboard_empty observed=0 expected>0");
      end
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         n_cmp++;
         assert (state === e.st) else begin
            n_fail++;
            $error("FAIL %s state observed=%0d expected=%0d", e.tag, state, e.st);
         end
         n_cmp++;
         assert (obs === e.ctl) else begin
            n_fail++;
            $error("FAIL %s ctrl observed=%h expected=%h", e.tag, obs, e.ctl);
         end
      end
   endtask

   // Called just after a rising edge: drive inputs, queue the expectation, check mid-cycle.
   task automatic cyc(input string tag, input logic [5:0] op, input logic mr,
                      input mc_state_type st, input logic fault);
      exp_t e;
      opcode    = op;
      mem_ready = mr;
      e.tag = tag;
      e.st  = st;
      e.ctl = model(st, op, mr, fault);
      sb_q.push_back(e);
      @(negedge clk);
      check_out();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      opcode    = 6'h00;
      mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      cyc("reset", 6'h00, 1'b1, IDLE, 1'b0);
      rst_n = 1'b1;
      cyc("idle", 6'h00, 1'b1, IDLE, 1'b0);

      // lw, no waits: 5 cycles
      cyc("lw_if",  6'h23, 1'b1, FETCH,    1'b0);
      cyc("lw_id",  6'h23, 1'b1, DECODE,   1'b0);
      cyc("lw_ex",  6'h23, 1'b1, MEM_ADDR, 1'b0);
      cyc("lw_mem", 6'h23, 1'b1, MEM_READ, 1'b0);
      cyc("lw_wb",  6'h23, 1'b1, MEM_WB,   1'b0);

      // sw with three wait cycles in MEM_WRITE: 7 cycles
      cyc("sw_if", 6'h2B, 1'b1, FETCH,    1'b0);
      cyc("sw_id", 6'h2B, 1'b1, DECODE,   1'b0);
      cyc("sw_ex", 6'h2B, 1'b1, MEM_ADDR, 1'b0);
      for (int i = 0; i < 3; i++) cyc("sw_wait", 6'h2B, 1'b0, MEM_WRITE, 1'b0);
      cyc("sw_done", 6'h2B, 1'b1, MEM_WRITE, 1'b0);

      cyc("beq_if", 6'h04, 1'b1, FETCH,  1'b0);
      cyc("beq_id", 6'h04, 1'b1, DECODE, 1'b0);
      cyc("beq_br", 6'h04, 1'b1, BRANCH, 1'b0);

      cyc("r_if", 6'h00, 1'b1, FETCH,  1'b0);
      cyc("r_id", 6'h00, 1'b1, DECODE, 1'b0);
      cyc("r_ex", 6'h00, 1'b1, R_EXEC, 1'b0);
      cyc("r_wb", 6'h00, 1'b1, R_WB,   1'b0);

      cyc("addi_if", 6'h08, 1'b1, FETCH,     1'b0);
      cyc("addi_id", 6'h08, 1'b1, DECODE,    1'b0);
      cyc("addi_ex", 6'h08, 1'b1, ADDI_EXEC, 1'b0);
      cyc("addi_wb", 6'h08, 1'b1, ADDI_WB,   1'b0);

      cyc("ill_if", 6'h3F, 1'b1, FETCH,  1'b0);
      cyc("ill_id", 6'h3F, 1'b1, DECODE, 1'b0);

      cyc("j_if", 6'h02, 1'b1, FETCH,  1'b0);
      cyc("j_id", 6'h02, 1'b1, DECODE, 1'b0);
`ifdef MULTICYCLE_JUMP_EN
      cyc("j_jmp", 6'h02, 1'b1, JUMP, 1'b0);
`endif

      // mem_ready arriving exactly in the timeout cycle completes normally
      for (int i = 0; i < 15; i++) cyc("if_wait", 6'h23, 1'b0, FETCH, 1'b0);
      cyc("if_edge", 6'h23, 1'b1, FETCH,    1'b0);
      cyc("lw2_id",  6'h23, 1'b1, DECODE,   1'b0);
      cyc("lw2_ex",  6'h23, 1'b1, MEM_ADDR, 1'b0);
      for (int i = 0; i < 15; i++) cyc("rd_wait", 6'h23, 1'b0, MEM_READ, 1'b0);
      cyc("rd_edge", 6'h23, 1'b1, MEM_READ, 1'b0);
      cyc("lw2_wb",  6'h23, 1'b1, MEM_WB,   1'b0);

      // MEM_READ timeout aborts back to FETCH
      cyc("lw3_if", 6'h23, 1'b1, FETCH,    1'b0);
      cyc("lw3_id", 6'h23, 1'b1, DECODE,   1'b0);
      cyc("lw3_ex", 6'h23, 1'b1, MEM_ADDR, 1'b0);
      for (int i = 0; i < 16; i++) cyc("rd_tmo", 6'h23, 1'b0, MEM_READ, (i == 15));

      // MEM_WRITE timeout: no retire
      cyc("sw2_if", 6'h2B, 1'b1, FETCH,    1'b0);
      cyc("sw2_id", 6'h2B, 1'b1, DECODE,   1'b0);
      cyc("sw2_ex", 6'h2B, 1'b1, MEM_ADDR, 1'b0);
      for (int i = 0; i < 16; i++) cyc("wr_tmo", 6'h2B, 1'b0, MEM_WRITE, (i == 15));

      // FETCH never answered: fault every 16 cycles
      for (int i = 0; i < 32; i++) cyc("if_tmo", 6'h00, 1'b0, FETCH, ((i % 16) == 15));

      // reset mid-instruction abandons it without a retire
      cyc("r2_if", 6'h00, 1'b1, FETCH,  1'b0);
      cyc("r2_id", 6'h00, 1'b1, DECODE, 1'b0);
      rst_n = 1'b0;
      cyc("r2_ex", 6'h00, 1'b1, R_EXEC, 1'b0);
      rst_n = 1'b1;
      cyc("r2_rst", 6'h00, 1'b1, IDLE,  1'b0);
      cyc("r2_if2", 6'h00, 1'b1, FETCH, 1'b0);

      n_cmp++;
      assert (sb_q.size() == 0) else begin
         n_fail++;
         $error("FAIL scoreboard_drain observed=%0d expected=0", sb_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
